store_trace_fifo: RTL and testbench

//  Store-trace buffer downstream of main_module's data-memory write port (mem_write/data_addr/write_data).

---
 rtl/store_trace_fifo.sv | 154 +++++++++++++++
 tb/tb_store_trace_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/store_trace_fifo.sv
// Store-trace buffer: queues CPU stores and presents them one at a time,
// each held on the display outputs for HOLD_CYCLES clocks.
module store_trace_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 50_000_000,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  freeze,
  output logic                  disp_valid,
  output logic [ADDR_W-1:0]     disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic [PTR_W:0]        fill_level,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam int EW = ADDR_W + DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SHOW = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [EW-1:0]           mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          count_q, count_d;
  logic                    disp_valid_q, disp_valid_d;
  logic [ADDR_W-1:0]       disp_addr_q, disp_addr_d;
  logic [DATA_WIDTH-1:0]   disp_data_q, disp_data_d;
  logic                    overflow_q;
  logic [7:0]              drop_count_q;

  logic                    pop_s, full_s, drop_s, wr_en_s, pop_slot_s;
  logic [EW-1:0]           head_s;
  logic                    unused_addr_s;

  assign unused_addr_s = ^data_addr[DATA_WIDTH-1:ADDR_W];
  assign head_s        = mem_q[rd_ptr_q];

  // Pop/push qualification; the registered count decides emptiness, so a push never bypasses.
  always_comb begin
    pop_slot_s = 1'b0;
    case (state_q)
      S_IDLE:  pop_slot_s = 1'b1;
      S_SHOW:  pop_slot_s = 1'b1;
      S_HOLD:  pop_slot_s = (timer_q == {TW{1'b0}});
      default: pop_slot_s = 1'b0;
    endcase
    pop_s   = pop_slot_s && (count_q != {(PTR_W+1){1'b0}}) && !freeze;
    full_s  = (count_q == (PTR_W+1)'(DEPTH));
    drop_s  = mem_write && full_s && !pop_s;
    wr_en_s = mem_write && !drop_s;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Next state and hold timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (pop_s) begin
      state_d = S_HOLD;
      timer_d = TW'(HOLD_CYCLES - 1);
    end else if (freeze) begin
      state_d = state_q;
      timer_d = timer_q;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (timer_q == {TW{1'b0}}) begin
            state_d = S_SHOW;
          end else begin
            timer_d = timer_q - {{(TW-1){1'b0}}, 1'b1};
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Display registers load the FIFO head on every pop.
  always_comb begin
    if (pop_s) begin
      disp_valid_d = 1'b1;
      disp_addr_d  = head_s[EW-1:DATA_WIDTH];
      disp_data_d  = head_s[DATA_WIDTH-1:0];
    end else begin
      disp_valid_d = disp_valid_q;
      disp_addr_d  = disp_addr_q;
      disp_data_d  = disp_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= {TW{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {(PTR_W+1){1'b0}};
      disp_valid_q <= 1'b0;
      disp_addr_q  <= {ADDR_W{1'b0}};
      disp_data_q  <= {DATA_WIDTH{1'b0}};
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      disp_valid_q <= disp_valid_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      wr_ptr_q     <= wr_en_s ? wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
      rd_ptr_q     <= pop_s ? rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : rd_ptr_q;
      overflow_q   <= overflow_q | drop_s;
      drop_count_q <= (drop_s && (drop_count_q != 8'hFF)) ? drop_count_q + 8'd1 : drop_count_q;
    end
  end

  // Entry storage; cleared on reset so stale stores never reappear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {data_addr[ADDR_W-1:0], write_data};
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign fill_level = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_store_trace_fifo.sv
// Directed bench for store_trace_fifo with DEPTH=4, HOLD_CYCLES=4.
module tb_store_trace_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic        freeze;
  logic        disp_valid;
  logic [9:0]  disp_addr;
  logic [31:0] disp_data;
  logic [2:0]  fill_level;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  store_trace_fifo #(
    .DATA_WIDTH(32), .ADDR_W(10), .DEPTH(4), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_addr(data_addr),
    .write_data(write_data), .freeze(freeze), .disp_valid(disp_valid),
    .disp_addr(disp_addr), .disp_data(disp_data), .fill_level(fill_level),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mw;
    logic [31:0] a;
    logic [31:0] d;
    logic        fr;
    logic        ev;
    logic [9:0]  ea;
    logic [31:0] ed;
    logic [2:0]  ef;
    logic        eo;
    logic [7:0]  edc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic mw, input logic [31:0] a,
                              input logic [31:0] d, input logic fr, input logic ev,
                              input logic [9:0] ea, input logic [31:0] ed,
                              input logic [2:0] ef, input logic eo, input logic [7:0] edc);
    vec_t v;
    v.rst = rst; v.mw = mw; v.a = a; v.d = d; v.fr = fr;
    v.ev = ev; v.ea = ea; v.ed = ed; v.ef = ef; v.eo = eo; v.edc = edc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string nm, input logic ev, input logic [9:0] ea,
                            input logic [31:0] ed, input logic [2:0] ef,
                            input logic eo, input logic [7:0] edc);
    chk({nm, ".valid"},    {31'd0, disp_valid}, {31'd0, ev});
    chk({nm, ".addr"},     {22'd0, disp_addr},  {22'd0, ea});
    chk({nm, ".data"},     disp_data,           ed);
    chk({nm, ".fill"},     {29'd0, fill_level}, {29'd0, ef});
    chk({nm, ".overflow"}, {31'd0, overflow},   {31'd0, eo});
    chk({nm, ".drops"},    {24'd0, drop_count}, {24'd0, edc});
  endtask

  task automatic step(input logic rst, input logic mw, input logic [31:0] a,
                      input logic [31:0] d, input logic fr);
    @(negedge clk);
    reset = rst; mem_write = mw; data_addr = a; write_data = d; freeze = fr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  t4_a [4];
    logic [31:0] t4_d [4];

    reset = 1'b0; mem_write = 1'b0; data_addr = 32'd0; write_data = 32'd0; freeze = 1'b0;

    // Reset with a store present, then test 1 and test 2 as per-cycle vectors.
    vq.push_back(mk(1'b0, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0, 10'd0, 32'd0, 3'd0, 1'b0, 8'd0));
    vq.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'd0, 1'b0, 8'd0));
    vq.push_back(mk(1'b1, 1'b1, 32'h64, 32'd25, 1'b0, 1'b0, 10'd0, 32'd0, 3'd1, 1'b0, 8'd0));
    for (int i = 0; i < 6; i++)
      vq.push_back(mk(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 10'd100, 32'd25, 3'd0, 1'b0, 8'd0));
    vq.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'd0, 1'b0, 8'd0));
    vq.push_back(mk(1'b1, 1'b1, 32'd4, 32'd7, 1'b0, 1'b0, 10'd0, 32'd0, 3'd1, 1'b0, 8'd0));
    vq.push_back(mk(1'b1, 1'b1, 32'd8, 32'd9, 1'b0, 1'b1, 10'd4, 32'd7, 3'd1, 1'b0, 8'd0));
    vq.push_back(mk(1'b1, 1'b1, 32'd12, 32'd42, 1'b0, 1'b1, 10'd4, 32'd7, 3'd2, 1'b0, 8'd0));
    for (int i = 0; i < 2; i++)
      vq.push_back(mk(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 10'd4, 32'd7, 3'd2, 1'b0, 8'd0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 10'd8, 32'd9, 3'd1, 1'b0, 8'd0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 10'd12, 32'd42, 3'd0, 1'b0, 8'd0));

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].mw, vq[i].a, vq[i].d, vq[i].fr);
      expect_out($sformatf("vec%0d", i), vq[i].ev, vq[i].ea, vq[i].ed, vq[i].ef,
                 vq[i].eo, vq[i].edc);
    end

    // Test 3: freeze after first display, fill to full, one drop, then saturate.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'd1, 32'd11, 1'b0);
    step(1'b1, 1'b1, 32'd2, 32'd22, 1'b0);
    expect_out("t3_first", 1'b1, 10'd1, 32'd11, 3'd1, 1'b0, 8'd0);
    for (int i = 3; i <= 6; i++) step(1'b1, 1'b1, i, i * 11, 1'b1);
    expect_out("t3_full", 1'b1, 10'd1, 32'd11, 3'd4, 1'b1, 8'd1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 32'd100, 32'd100, 1'b1);
    expect_out("t3_sat", 1'b1, 10'd1, 32'd11, 3'd4, 1'b1, 8'd255);

    // Test 4: pop and push on the same edge while full.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    expect_out("t4_pre", 1'b1, 10'd1, 32'd11, 3'd4, 1'b1, 8'd255);
    step(1'b1, 1'b1, 32'd77, 32'd777, 1'b0);
    expect_out("t4_swap", 1'b1, 10'd2, 32'd22, 3'd4, 1'b1, 8'd255);
    t4_a[0] = 10'd3;  t4_d[0] = 32'd33;
    t4_a[1] = 10'd4;  t4_d[1] = 32'd44;
    t4_a[2] = 10'd5;  t4_d[2] = 32'd55;
    t4_a[3] = 10'd77; t4_d[3] = 32'd777;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
      chk($sformatf("t4_hold%0d", k), {22'd0, disp_addr},
          {22'd0, (k == 0) ? 10'd2 : t4_a[k-1]});
      step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
      expect_out($sformatf("t4_pop%0d", k), 1'b1, t4_a[k], t4_d[k], 3'(3 - k), 1'b1, 8'd255);
    end

    // Test 5: freeze with timer==2, then the next pop exactly 3 edges after release.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    expect_out("t5_reset", 1'b0, 10'd0, 32'd0, 3'd0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 32'd5, 32'd55, 1'b0);
    step(1'b1, 1'b1, 32'd6, 32'd66, 1'b0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    expect_out("t5_start", 1'b1, 10'd5, 32'd55, 3'd1, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    expect_out("t5_frozen", 1'b1, 10'd5, 32'd55, 3'd1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    expect_out("t5_rel2", 1'b1, 10'd5, 32'd55, 3'd1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    expect_out("t5_pop", 1'b1, 10'd6, 32'd66, 3'd0, 1'b0, 8'd0);

    // Test 6: reset mid-burst discards the in-flight store.
    step(1'b1, 1'b1, 32'd9, 32'd9, 1'b0);
    step(1'b1, 1'b1, 32'd10, 32'd10, 1'b0);
    step(1'b0, 1'b1, 32'd11, 32'd11, 1'b0);
    expect_out("t6_reset", 1'b0, 10'd0, 32'd0, 3'd0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 32'd1, 32'd1, 1'b0);
    expect_out("t6_push", 1'b0, 10'd0, 32'd0, 3'd1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    expect_out("t6_show", 1'b1, 10'd1, 32'd1, 3'd0, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
